// File: rtl/imem_program_loader.sv
// imem_program_loader: encodes symbolic operation requests into 16-bit instructions and streams them
// into instruction memory one word per cycle. Define LOADER_CHECKSUM_EN to add a running word checksum.
module imem_program_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_end,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              err_op,
  output logic              err_imm,
  output logic              overflow,
  output logic              done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

  logic [1:0]        r_state;
  logic [15:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [PTR_W:0]    r_cnt;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [ADDR_W:0]   r_words;
  logic              r_err_op;
  logic              r_err_imm;
  logic              r_ovf;

  logic w_start;
  logic w_active;
  logic w_full;
  logic w_acc;
  logic w_op_bad;
  logic w_imm_bad;
  logic w_push;
  logic w_pop;
  logic w_top_hit;
  logic w_spill;

  function automatic logic is_itype(input logic [3:0] op);
    return (op == 4'd4) || ((op >= 4'd7) && (op <= 4'd10));
  endfunction

  function automatic logic [15:0] encode(input logic [3:0] op, input logic [2:0] rs,
                                         input logic [2:0] rt, input logic [2:0] rd,
                                         input logic [12:0] imm);
    logic [2:0] opc;
    case (op)
      4'd4:    opc = 3'b001;
      4'd5:    opc = 3'b010;
      4'd6:    opc = 3'b011;
      4'd7:    opc = 3'b100;
      4'd8:    opc = 3'b101;
      4'd9:    opc = 3'b110;
      4'd10:   opc = 3'b111;
      default: opc = 3'b000;
    endcase
    // R-type funct equals the request code for ADD/SUB/AND/OR
    if (op <= 4'd3)
      return {3'b000, rs, rt, rd, op};
    else if ((op == 4'd5) || (op == 4'd6))
      return {opc, imm};
    else
      return {opc, rs, rt, imm[6:0]};
  endfunction

  assign w_start   = (r_state == S_IDLE) && load_start;
  assign w_active  = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign w_full    = (r_cnt == CNT_FULL);
  assign in_ready  = (r_state == S_LOAD) && !w_full;
  assign w_acc     = in_valid && in_ready;
  assign w_op_bad  = (in_op > 4'd10);
  assign w_imm_bad = is_itype(in_op) && !((&in_imm[12:6]) || !(|in_imm[12:6]));
  assign w_push    = w_acc && !w_op_bad && !w_imm_bad;
  assign w_pop     = w_active && (r_cnt != '0);
  assign w_top_hit = w_pop && (&r_waddr);
  // Anything still queued or arriving alongside the top-address write is lost
  assign w_spill   = (r_cnt > CNT_ONE) || w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (load_start) r_state <= S_LOAD;
        S_LOAD:  if (w_top_hit) r_state <= S_DONE;
                 else if (load_end) r_state <= S_DRAIN;
        S_DRAIN: if (w_top_hit || (r_cnt == '0)) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: encoded-word FIFO
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= encode(in_op, in_rs, in_rt, in_rd, in_imm);
  end

  always_ff @(posedge clk) begin
    if (rst || w_top_hit) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Stage p1: registered memory write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_waddr <= '0;
      r_words <= '0;
    end else begin
      r_we <= w_pop;
      if (w_start) begin
        r_waddr <= load_base;
        r_words <= '0;
      end else if (w_pop) begin
        r_addr  <= r_waddr;
        r_wdata <= r_mem[r_rp];
        r_waddr <= r_waddr + 1'b1;
        r_words <= r_words + (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_err_op  <= 1'b0;
      r_err_imm <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_acc && w_op_bad)               r_err_op  <= 1'b1;
      if (w_acc && !w_op_bad && w_imm_bad) r_err_imm <= 1'b1;
      if (w_top_hit && w_spill)            r_ovf     <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_sum;

  // Summed at pop time so the total is complete when done pulses
  always_ff @(posedge clk) begin
    if (rst || w_start) r_sum <= '0;
    else if (w_pop)     r_sum <= r_sum + r_mem[r_rp];
  end

  assign checksum = r_sum;
`endif

  assign imem_we       = r_we;
  assign imem_addr     = r_addr;
  assign imem_wdata    = r_wdata;
  assign words_written = r_words;
  assign err_op        = r_err_op;
  assign err_imm       = r_err_imm;
  assign overflow      = r_ovf;
  assign done          = (r_state == S_DONE);

endmodule
